// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, the architectural zero register and the per-cycle control
// patterns the controller drives onto the IF/ID and ID/EX registers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_MC_WAIT  = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic ifid_flush;
        logic idex_flush;
        logic redirect;
    } ctrl_t;

    // Normal flow: everything advances, nothing squashed.
    localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // Freeze the front end and EX together (multi-cycle op in flight).
    localparam ctrl_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Bubble: hold PC and IF/ID, load an all-zero control word into ID/EX.
    localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Mispredict: squash both younger stages and take the EX target.
    localparam ctrl_t CTRL_SQUASH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_detect.sv
// Pure combinational hazard decode: load-use dependency between the load
// in EX and the instruction in ID, and branch/jump mispredict in EX.
module hazard_detect_comb
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memRead,
    input  logic       ex_branch,
    input  logic       ex_jump,
    input  logic       ex_prediction,
    input  logic       ex_taken,
    output logic       load_use,
    output logic       mispredict
);

    // A load writing x0 never creates a dependency.
    always_comb begin
        load_use   = id_valid & ex_memRead & (ex_rd != REG_X0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        mispredict = (ex_branch & (ex_taken != ex_prediction)) |
                     (ex_jump & ~ex_prediction);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives PC / IF/ID / ID/EX enables and flushes
// for load-use stalls, mispredict squashes and multi-cycle EX holds.
// Optional feature macro HAZARD_PERF_CNT_EN adds saturating stall_cnt and
// flush_cnt performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memRead,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic        ex_prediction,
    input  logic        ex_taken,
    input  logic        mc_start,
    input  logic        mc_done,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        redirect,
    output logic        mc_timeout,
    output logic [1:0]  state_out
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_set;
    logic             load_use, mispredict;
    ctrl_t            ctrl, ctrl_out;

    hazard_detect_comb u_detect (
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rd         (ex_rd),
        .ex_memRead    (ex_memRead),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_prediction (ex_prediction),
        .ex_taken      (ex_taken),
        .load_use      (load_use),
        .mispredict    (mispredict)
    );

    // Per-state control decode and next-state / counter selection.
    always_comb begin
        ctrl        = CTRL_RUN;
        state_nxt   = ST_RUN;
        cnt_nxt     = '0;
        timeout_set = 1'b0;
        case (state)
            ST_RUN: begin
                // Mispredict wins: the stalling instruction is squashed anyway.
                if (mispredict) begin
                    ctrl = CTRL_SQUASH;
                end else if (mc_start) begin
                    ctrl      = CTRL_HOLD;
                    state_nxt = ST_MC_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end else if (load_use) begin
                    ctrl      = CTRL_BUBBLE;
                    state_nxt = ST_LD_STALL;
                end
            end
            ST_LD_STALL: begin
                // The bubble is now in EX, so only a mispredict can matter.
                if (mispredict) ctrl = CTRL_SQUASH;
            end
            ST_MC_WAIT: begin
                // EX is frozen, so its branch fields are stale and ignored.
                if (!mc_done) begin
                    ctrl = CTRL_HOLD;
                    if (cnt == CNT_W'(MC_TIMEOUT - 1)) begin
                        timeout_set = 1'b1;
                    end else begin
                        state_nxt = ST_MC_WAIT;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // While reset is asserted the pipeline is left free-running.
    assign ctrl_out   = rst_n ? ctrl : CTRL_RUN;
    assign pc_write   = ctrl_out.pc_write;
    assign ifid_write = ctrl_out.ifid_write;
    assign idex_write = ctrl_out.idex_write;
    assign ifid_flush = ctrl_out.ifid_flush;
    assign idex_flush = ctrl_out.idex_flush;
    assign redirect   = ctrl_out.redirect;
    assign state_out  = state;

    // FSM state, MC_WAIT cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            cnt        <= '0;
            mc_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set) mc_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    // Saturating counts of stalled cycles and mispredict squashes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, ~ctrl.pc_write);
            flush_cnt <= sat_inc(flush_cnt, ctrl.redirect);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MC_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 0, ex_memRead = 0, ex_branch = 0, ex_jump = 0;
    logic       ex_prediction = 0, ex_taken = 0, mc_start = 0, mc_done = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic       pc_write, ifid_write, idex_write, ifid_flush, idex_flush, redirect, mc_timeout;
    logic [1:0] state_out;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_prediction(ex_prediction), .ex_taken(ex_taken), .mc_start(mc_start),
        .mc_done(mc_done), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .redirect(redirect), .mc_timeout(mc_timeout), .state_out(state_out)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Behavioural model: "stalled one cycle", "waiting on a multi-cycle op
    // for el cycles so far", sticky timeout, and event tallies.
    bit      m_stall = 0, m_wait = 0, m_to = 0;
    int      m_el = 0;
    longint  m_stalls = 0, m_flushes = 0;

    always @(negedge clk) begin
        bit lu, mp, e_pc, e_ifw, e_idw, e_iff, e_idf, e_red, n_stall;
        int e_st;
        if (!rst_n) begin
            chk("rst_pc_write", pc_write, 1);
            chk("rst_idex_write", idex_write, 1);
            chk("rst_flushes", {ifid_flush, idex_flush, redirect}, 0);
            chk("rst_state", state_out, 0);
            chk("rst_timeout", mc_timeout, 0);
`ifdef HAZARD_PERF_CNT_EN
            chk("rst_stall_cnt", stall_cnt, 0);
            chk("rst_flush_cnt", flush_cnt, 0);
`endif
            m_stall = 0; m_wait = 0; m_to = 0; m_el = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            lu = id_valid && ex_memRead && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
            mp = (ex_branch && (ex_taken != ex_prediction)) || (ex_jump && !ex_prediction);
            {e_pc, e_ifw, e_idw, e_iff, e_idf, e_red} = 6'b111000;
            e_st = m_wait ? 2 : (m_stall ? 1 : 0);
            n_stall = 0;
            if (m_wait) begin
                if (!mc_done) {e_pc, e_ifw, e_idw} = 3'b000;
            end else if (mp) begin
                {e_iff, e_idf, e_red} = 3'b111;
            end else if (!m_stall && mc_start) begin
                {e_pc, e_ifw, e_idw} = 3'b000;
            end else if (!m_stall && lu) begin
                {e_pc, e_ifw, e_idf} = 3'b001;
                n_stall = 1;
            end
            chk("pc_write", pc_write, e_pc);
            chk("ifid_write", ifid_write, e_ifw);
            chk("idex_write", idex_write, e_idw);
            chk("ifid_flush", ifid_flush, e_iff);
            chk("idex_flush", idex_flush, e_idf);
            chk("redirect", redirect, e_red);
            chk("state_out", state_out, e_st);
            chk("mc_timeout", mc_timeout, m_to);
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cnt", stall_cnt, m_stalls > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : m_stalls[31:0]);
            chk("flush_cnt", flush_cnt, m_flushes > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : m_flushes[31:0]);
`endif
            if (!e_pc) m_stalls++;
            if (e_red) m_flushes++;
            // Advance the model.
            if (m_wait) begin
                if (mc_done) m_wait = 0;
                else begin
                    m_el++;
                    if (m_el >= MC_TIMEOUT) begin m_wait = 0; m_to = 1; end
                end
            end else if (!mp && !m_stall && mc_start) begin
                m_wait = 1; m_el = 1;
            end
            m_stall = n_stall;
        end
    end

    task automatic idle();
        {id_valid, ex_memRead, ex_branch, ex_jump, ex_prediction, ex_taken, mc_start, mc_done} = '0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    endtask

    // Move to 1 time unit after the next rising edge (input drive point).
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        int holds;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Load-use on rs2.
        id_valid = 1; ex_memRead = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 3;
        #3 chk("lu_pc_write", pc_write, 0);
        chk("lu_idex_flush", idex_flush, 1);
        next_cycle(); idle();
        #3 chk("lu_stall_state", state_out, 2'b01);
        chk("lu_stall_enables", {pc_write, ifid_write, idex_write}, 3'b111);
        next_cycle();
        #3 chk("lu_back_run", state_out, 2'b00);

        // No stall when rd is x0 or ID holds no instruction.
        next_cycle();
        id_valid = 1; ex_memRead = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        #3 chk("lu_x0_pc_write", pc_write, 1);
        next_cycle();
        id_valid = 0; ex_rd = 5; id_rs2 = 5;
        #3 chk("lu_invalid_pc_write", pc_write, 1);
        next_cycle(); idle();

        // Mispredict beats a coincident load-use.
        ex_branch = 1; ex_prediction = 0; ex_taken = 1;
        id_valid = 1; ex_memRead = 1; ex_rd = 7; id_rs1 = 7;
        #3 chk("mp_flushes", {ifid_flush, idex_flush, redirect}, 3'b111);
        chk("mp_pc_write", pc_write, 1);
        next_cycle(); idle();
        #3 chk("mp_state_run", state_out, 2'b00);

        // Multi-cycle op finishing after 5 held cycles.
        next_cycle();
        mc_start = 1;
        for (int i = 0; i < 5; i++) begin
            #3 chk("mc_hold", {pc_write, ifid_write, idex_write}, 3'b000);
            next_cycle(); mc_start = 0;
        end
        mc_done = 1;
        #3 chk("mc_done_enables", {pc_write, ifid_write, idex_write}, 3'b111);
        chk("mc_done_no_timeout", mc_timeout, 0);
        next_cycle(); idle();
        #3 chk("mc_done_state", state_out, 2'b00);

        // Multi-cycle op that never completes.
        next_cycle();
        mc_start = 1; holds = 0;
        for (int i = 0; i < 200; i++) begin
            #3;
            if (pc_write) break;
            holds++;
            next_cycle(); mc_start = 0;
        end
        chk("mc_timeout_len", holds, MC_TIMEOUT);
        chk("mc_timeout_set", mc_timeout, 1);
        chk("mc_timeout_state", state_out, 2'b00);
        next_cycle();

        // Randomized traffic with small register numbers to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_memRead    = ($urandom_range(0, 2) == 0);
            ex_branch     = ($urandom_range(0, 4) == 0);
            ex_jump       = ($urandom_range(0, 9) == 0);
            ex_prediction = 1'($urandom_range(0, 1));
            ex_taken      = 1'($urandom_range(0, 1));
            mc_start      = m_stall ? 1'b0 : ($urandom_range(0, 19) == 0);
            mc_done       = ($urandom_range(0, 7) == 0);
            next_cycle();
        end
        idle();
        #3 chk("timeout_sticky", mc_timeout, 1);

        // Asynchronous reset in the middle of MC_WAIT.
        next_cycle();
        mc_start = 1;
        next_cycle(); mc_start = 0;
        next_cycle();
        #2 rst_n = 1'b0;
        #1 chk("arst_state", state_out, 2'b00);
        chk("arst_enables", {pc_write, ifid_write, idex_write}, 3'b111);
        chk("arst_flushes", {ifid_flush, idex_flush, redirect}, 3'b000);
        chk("arst_timeout", mc_timeout, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
`endif
        next_cycle();
        rst_n = 1'b1;
        repeat (3) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
